// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with 16x oversampling from an internal clock divider.
// Emits a 1-cycle rx_valid per good frame and rx_frame_err on a low stop bit.
module uart_rx_8n1 #(
    parameter int  CLK_FREQ = 12000000,
    parameter int  BAUD     = 9600,
    localparam int DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sync1;
    logic               r_rx_s;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [3:0]         r_ovs_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;

    logic               w_tick;
    logic               w_enter_start;
    logic               w_start_ok;
    logic               w_sample;
    logic               w_good;
    logic               w_bad;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_comb begin
        w_state_next  = r_state;
        w_enter_start = 1'b0;
        w_start_ok    = 1'b0;
        w_sample      = 1'b0;
        w_good        = 1'b0;
        w_bad         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next  = S_START;
                    w_enter_start = 1'b1;
                end
            end
            S_START: begin
                // Re-check the line half a bit in to reject short glitches.
                if (w_tick && (r_ovs_cnt == 4'd7)) begin
                    if (!r_rx_s) begin
                        w_state_next = S_DATA;
                        w_start_ok   = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_tick && (r_ovs_cnt == 4'd15)) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tick && (r_ovs_cnt == 4'd15)) begin
                    if (r_rx_s) begin
                        w_good       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_bad        = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Stay here while the line is held low so a break is not
                // mistaken for a stream of start bits.
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_div_cnt   <= '0;
            r_ovs_cnt   <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1 <= uart_rx;
            r_rx_s  <= r_sync1;
            r_state <= w_state_next;

            if (w_enter_start) begin
                r_div_cnt <= '0;
                r_ovs_cnt <= 4'd0;
            end else if (r_state != S_IDLE) begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    // Re-align the oversample phase to the start-bit centre.
                    r_ovs_cnt <= w_start_ok ? 4'd0 : r_ovs_cnt + 4'd1;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end

            if (w_start_ok) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_sample) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end

            if (w_good) begin
                r_data <= r_shift;
            end
            r_valid     <= w_good;
            r_frame_err <= w_bad;
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1 at DIV=10 (160 clocks per bit).
// Stimulus pushes expected strobes; a monitor pops and checks them.
module tb_uart_rx_8n1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx_8n1 #(
        .CLK_FREQ(1600000),
        .BAUD    (10000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vtimes[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || rx_frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b data=0x%0h, required no strobe (cycle %0d)",
                         rx_valid, rx_frame_err, rx_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_kind{valid,err}", {30'd0, rx_valid, rx_frame_err},
                    e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    chk("busy_at_strobe", {31'd0, rx_busy}, 32'd0);
                    vtimes.push_back(cyc);
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input int bitlen, input logic stop);
        logic [7:0] b;
        b = d;
        uart_rx = 1'b0;
        wait_clks(bitlen);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clks(bitlen);
        end
        uart_rx = stop;
        wait_clks(bitlen);
    endtask

    task automatic expect_good(input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        logic [7:0] pat;
        int gap;

        // Reset state
        wait_clks(3);
        chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        chk("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        wait_clks(20);

        // Single frame 0xA5
        expect_good(8'hA5);
        send_frame(8'hA5, 160, 1'b1);
        wait_clks(200);
        chk("a5_all_seen", exp_q.size(), 32'd0);

        // Back-to-back 0x00, 0xFF, 0x55
        vtimes.delete();
        expect_good(8'h00);
        expect_good(8'hFF);
        expect_good(8'h55);
        send_frame(8'h00, 160, 1'b1);
        send_frame(8'hFF, 160, 1'b1);
        send_frame(8'h55, 160, 1'b1);
        wait_clks(200);
        chk("b2b_all_seen", exp_q.size(), 32'd0);
        chk("b2b_strobe_count", vtimes.size(), 32'd3);
        if (vtimes.size() == 3) begin
            gap = vtimes[1] - vtimes[0];
            chk("b2b_gap01_near_1600", {31'd0, (gap >= 1595 && gap <= 1605)}, 32'd1);
            gap = vtimes[2] - vtimes[1];
            chk("b2b_gap12_near_1600", {31'd0, (gap >= 1595 && gap <= 1605)}, 32'd1);
        end

        // 40-clock low glitch on idle line
        uart_rx = 1'b0;
        wait_clks(40);
        uart_rx = 1'b1;
        wait_clks(20);
        chk("glitch_busy_mid", {31'd0, rx_busy}, 32'd1);
        wait_clks(200);
        chk("glitch_busy_after", {31'd0, rx_busy}, 32'd0);
        chk("glitch_rx_data_kept", {24'd0, rx_data}, 32'h55);

        // Frame error: 0x3C with low stop, then a long break
        e.is_err = 1'b1;
        e.data   = 8'h00;
        exp_q.push_back(e);
        send_frame(8'h3C, 160, 1'b0);
        wait_clks(3000);
        chk("ferr_all_seen", exp_q.size(), 32'd0);
        chk("break_busy", {31'd0, rx_busy}, 32'd1);
        chk("ferr_rx_data_kept", {24'd0, rx_data}, 32'h55);
        uart_rx = 1'b1;
        wait_clks(50);
        chk("break_released", {31'd0, rx_busy}, 32'd0);
        expect_good(8'h81);
        send_frame(8'h81, 160, 1'b1);
        wait_clks(200);
        chk("after_break_all_seen", exp_q.size(), 32'd0);

        // Reset in the middle of bit 4 of 0xE0 (remaining bits idle-high)
        pat = 8'hE0;
        uart_rx = 1'b0;
        wait_clks(160);
        for (int i = 0; i < 4; i++) begin
            uart_rx = pat[i];
            wait_clks(160);
        end
        uart_rx = pat[4];
        wait_clks(80);
        chk("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, rx_busy}, 32'd0);
        chk("async_reset_rx_data", {24'd0, rx_data}, 32'h00);
        wait_clks(80);
        uart_rx = 1'b1;
        wait_clks(20);
        rst_n = 1'b1;
        wait_clks(140 + 160 * 3 + 200);
        chk("post_reset_idle", {31'd0, rx_busy}, 32'd0);
        expect_good(8'h7E);
        send_frame(8'h7E, 160, 1'b1);
        wait_clks(200);
        chk("after_reset_all_seen", exp_q.size(), 32'd0);

        // Baud skew about -4% / +4%
        expect_good(8'hC3);
        send_frame(8'hC3, 154, 1'b1);
        wait_clks(300);
        chk("skew_fast_seen", exp_q.size(), 32'd0);
        expect_good(8'hC3);
        send_frame(8'hC3, 166, 1'b1);
        wait_clks(300);
        chk("skew_slow_seen", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
